divu: RTL and testbench

Iterative unsigned divider, the inverse datapath of the unsigned multiplier in the ALU group. Accepts a 32-bit dividend and divisor on a start pulse, runs one restoring-division step per clock, and returns a 32-bit quotient and remainder with a one-cycle done pulse. It sits beside the multiplier behind the HI/LO write path; the multiplier feeds LO/HI with product, this block with quotient and remainder.

---
 rtl/divu_pkg.sv | 18 +
 rtl/divu_step.sv | 24 ++
 rtl/divu.sv | 104 ++++++++++
 tb/tb_divu.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/divu_pkg.sv
// Shared types and constants for the iterative unsigned divider.
// Optional build macro: DIVU_FAST_ZERO_EN (see divu.sv).
package divu_pkg;

    localparam int DIVU_WIDTH = 32;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = cnt_w(DIVU_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits, record the quotient bit.
module divu_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] wq_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] wq_o
);

    logic [W:0] shl;
    logic [W:0] diff;
    logic       fits;

    // The partial remainder can reach 2*div-1, so the compare needs one extra bit.
    assign shl   = {rem_i, wq_i[W-1]};
    assign diff  = shl - {1'b0, div_i};
    assign fits  = (shl >= {1'b0, div_i});
    assign rem_o = fits ? diff[W-1:0] : shl[W-1:0];
    assign wq_o  = {wq_i[W-2:0], fits};

endmodule

// File: rtl/divu.sv
// Iterative unsigned divider: one restoring step per clock, WIDTH steps per result.
// Define DIVU_FAST_ZERO_EN to answer a zero divisor on the acceptance edge.
module divu
    import divu_pkg::*;
#(
    parameter int WIDTH = DIVU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int              CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, wq_q, div_q;
    logic [WIDTH-1:0] rem_d, wq_d;
    logic [WIDTH-1:0] q_q, r_q;
    logic             busy_q, done_q, dz_q;

    divu_step #(.W(WIDTH)) u_step (
        .rem_i (rem_q),
        .wq_i  (wq_q),
        .div_i (div_q),
        .rem_o (rem_d),
        .wq_o  (wq_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            wq_q    <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef DIVU_FAST_ZERO_EN
                        if (b == '0) begin
                            // Same answer the full iteration would give, without the wait.
                            q_q    <= '1;
                            r_q    <= a;
                            dz_q   <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            wq_q    <= a;
                            div_q   <= b;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
`else
                        wq_q    <= a;
                        div_q   <= b;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    wq_q  <= wq_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        q_q     <= wq_d;
                        r_q     <= rem_d;
                        dz_q    <= (div_q == '0);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_divu.sv
// Directed self-checking bench for divu; honours DIVU_FAST_ZERO_EN when defined.
module tb_divu;

    localparam int W = 32;
`ifdef DIVU_FAST_ZERO_EN
    localparam int  ZLAT  = 0;
    localparam logic ZBUSY = 1'b0;
`else
    localparam int  ZLAT  = 32;
    localparam logic ZBUSY = 1'b1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic [W-1:0] q, r;
    logic         busy, done, dz;

    int passed = 0;
    int total  = 0;

    divu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    // Present operands with start for one edge; returns at the negedge after acceptance.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges after acceptance until done is seen (0 = seen right away).
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; a = 100; b = 7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({busy, done, dz, q, r} !== '0) $display("FAIL reset_hold busy=%b done=%b q=%0d r=%0d want all 0", busy, done, q, r);
            else passed++;
        end
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== '0) $display("FAIL reset_release busy=%b done=%b q=%0d want 0", busy, done, q);
        else passed++;
    endtask

    task automatic test_basic();
        int lat;
        launch(100, 7);
        total++;
        if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy);
        else passed++;
        wait_done(lat);
        total++;
        if (lat !== 32) $display("FAIL basic_latency got %0d want 32", lat);
        else passed++;
        total++;
        if (q !== 14 || r !== 2 || dz !== 1'b0 || busy !== 1'b0) $display("FAIL basic_result q=%0d r=%0d dz=%b busy=%b want 14 2 0 0", q, r, dz, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done);
        else passed++;
        repeat (6) @(negedge clk);
        total++;
        if (q !== 14 || r !== 2) $display("FAIL basic_hold q=%0d r=%0d want 14 2", q, r);
        else passed++;
    endtask

    task automatic test_patterns();
        logic [W-1:0] va [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        logic [W-1:0] vb [3] = '{32'hFFFF_FFFF, 32'd1,         32'd9};
        logic [W-1:0] eq [3] = '{32'd1,         32'hFFFF_FFFF, 32'd0};
        logic [W-1:0] er [3] = '{32'd0,         32'd0,         32'd5};
        int lat;
        for (int i = 0; i < 3; i++) begin
            launch(va[i], vb[i]);
            wait_done(lat);
            total++;
            if (lat !== 32 || q !== eq[i] || r !== er[i] || dz !== 1'b0)
                $display("FAIL pattern%0d lat=%0d q=%h r=%h dz=%b want 32 %h %h 0", i, lat, q, r, dz, eq[i], er[i]);
            else passed++;
        end
    endtask

    task automatic test_div_zero();
        int lat;
        launch(32'hB3, 0);
        total++;
        if (busy !== ZBUSY) $display("FAIL zero_busy got %b want %b", busy, ZBUSY);
        else passed++;
        wait_done(lat);
        total++;
        if (lat !== ZLAT) $display("FAIL zero_latency got %0d want %0d", lat, ZLAT);
        else passed++;
        total++;
        if (q !== 32'hFFFF_FFFF || r !== 32'hB3 || dz !== 1'b1) $display("FAIL zero_result q=%h r=%h dz=%b want ffffffff b3 1", q, r, dz);
        else passed++;
    endtask

    task automatic test_ignore_start();
        int lat;
        launch(1000, 7);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5 || lat == 20) begin
                a = (lat == 5) ? 50 : 9;
                b = (lat == 5) ? 3 : 2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (lat == 10) begin
                total++;
                if (q !== 32'hFFFF_FFFF || r !== 32'hB3 || dz !== 1'b1) $display("FAIL run_undisturbed q=%h r=%h dz=%b want previous result", q, r, dz);
                else passed++;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        total++;
        if (lat !== 32 || q !== 142 || r !== 6 || dz !== 1'b0) $display("FAIL ignore_start lat=%0d q=%0d r=%0d dz=%b want 32 142 6 0", lat, q, r, dz);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        // Still in the done cycle of the previous division.
        a = 255; b = 16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_accept busy=%b done=%b want 1 0", busy, done);
        else passed++;
        wait_done(lat);
        total++;
        if (lat !== 32 || q !== 15 || r !== 15) $display("FAIL b2b_result lat=%0d q=%0d r=%0d want 32 15 15", lat, q, r);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit seen = 1'b0;
        launch(1000, 3);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({busy, done, dz, q, r} !== '0) $display("FAIL midrun_clear busy=%b done=%b q=%0d r=%0d want all 0", busy, done, q, r);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL midrun_no_done activity=%b want 0", seen);
        else passed++;
        launch(1000, 3);
        wait_done(lat);
        total++;
        if (lat !== 32 || q !== 333 || r !== 1) $display("FAIL midrun_restart lat=%0d q=%0d r=%0d want 32 333 1", lat, q, r);
        else passed++;
    endtask

    initial begin
        start = 1'b0; a = '0; b = '0; reset = 1'b0;
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
